cnn_host: RTL

Host-side command engine for the CNN accelerator. It sits on the PS/DMA side of the parameter (ps), input (in), weight (w), bias (b) and output (out) block RAMs, opposite the accelerator core. It decodes a 32-bit command stream and does three jobs: writes segments into the ps/in/w/b memories, drives the core's start/done handshake, and streams results back out of the out memory.

---
 rtl/cnn_host_if.sv | 16 +
 rtl/cnn_host.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cnn_host_if.sv
// Command/data input stream and readback output stream between the PS/DMA side and cnn_host.
interface cnn_host_if #(parameter int DATA_SIZE = 32);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_last;

  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data, m_last);
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/cnn_host.sv
// Host command engine: decodes header/data words into BRAM segment writes,
// drives the core start/done handshake, and streams the out memory back.
module cnn_host #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 32,
  parameter int CNT_SIZE  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  cnn_host_if.slave            bus,
  output logic [MEM_SIZE-1:0]  wr_ad,
  output logic [DATA_SIZE-1:0] wr_wd,
  output logic [3:0]           ps_we,
  output logic [3:0]           in_we,
  output logic [3:0]           w_we,
  output logic [3:0]           b_we,
  output logic [MEM_SIZE-1:0]  out_ad,
  input  logic [DATA_SIZE-1:0] out_rd,
  output logic                 cnn_en,
  input  logic                 cnn_done,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, RUN, WAIT, RB_REQ, RB_CAP, RB_OUT} state_t;

  state_t              state, state_nx;
  logic [3:0]          op;
  logic [3:0]          hdr_op;
  logic [CNT_SIZE-1:0] cnt, idx, idx_nx, hdr_cnt;
  logic [MEM_SIZE-1:0] idx_w, idx_nx_w, idx_ad, idx_nx_ad;
  logic                s_fire, m_fire, last_word;

  assign hdr_op    = bus.s_data[DATA_SIZE-1 -: 4];
  assign hdr_cnt   = bus.s_data[CNT_SIZE-1:0];
  assign s_fire    = bus.s_valid && bus.s_ready;
  assign m_fire    = bus.m_valid && bus.m_ready;
  assign last_word = (idx == cnt - CNT_SIZE'(1));
  assign idx_nx    = idx + CNT_SIZE'(1);
  assign idx_w     = MEM_SIZE'(idx);
  assign idx_nx_w  = MEM_SIZE'(idx_nx);
  assign idx_ad    = {idx_w[MEM_SIZE-3:0], 2'b00};
  assign idx_nx_ad = {idx_nx_w[MEM_SIZE-3:0], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    cnn_en      = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        state_nx = HDR;
      end
      HDR: begin
        busy        = 1'b0;
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          case (hdr_op)
            4'd0, 4'd1, 4'd2, 4'd3: if (hdr_cnt != '0) state_nx = LOAD;
            4'd4:                   state_nx = RUN;
            4'd5:                   if (hdr_cnt != '0) state_nx = RB_REQ;
            default:                state_nx = HDR;
          endcase
        end
      end
      LOAD: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid && (last_word || bus.s_last)) state_nx = HDR;
      end
      RUN: begin
        cnn_en   = 1'b1;
        state_nx = WAIT;
      end
      WAIT:   if (cnn_done) state_nx = HDR;
      RB_REQ: state_nx = RB_CAP;
      RB_CAP: state_nx = RB_OUT;
      RB_OUT: begin
        bus.m_valid = 1'b1;
        bus.m_last  = last_word;
        if (bus.m_ready) state_nx = last_word ? HDR : RB_REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write enables are single-cycle pulses; address and data simply hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op         <= '0;
      cnt        <= '0;
      idx        <= '0;
      err        <= 1'b0;
      wr_ad      <= '0;
      wr_wd      <= '0;
      ps_we      <= '0;
      in_we      <= '0;
      w_we       <= '0;
      b_we       <= '0;
      out_ad     <= '0;
      bus.m_data <= '0;
    end else begin
      ps_we <= '0;
      in_we <= '0;
      w_we  <= '0;
      b_we  <= '0;
      case (state)
        HDR: if (s_fire) begin
          op     <= hdr_op;
          cnt    <= hdr_cnt;
          idx    <= '0;
          out_ad <= '0;
          if (hdr_op > 4'd5) err <= 1'b1;
        end
        LOAD: if (s_fire) begin
          wr_ad <= idx_ad;
          wr_wd <= bus.s_data;
          case (op)
            4'd0:    ps_we <= 4'hF;
            4'd1:    in_we <= 4'hF;
            4'd2:    w_we  <= 4'hF;
            default: b_we  <= 4'hF;
          endcase
          if (bus.s_last && !last_word) err <= 1'b1;
          idx <= idx_nx;
        end
        RB_CAP: bus.m_data <= out_rd;
        // Next read address is presented during RB_REQ so out_rd lands in RB_CAP.
        RB_OUT: if (m_fire) begin
          idx    <= idx_nx;
          out_ad <= idx_nx_ad;
        end
        default: ;
      endcase
    end
  end

endmodule
